sipo_frame_ctrl: RTL

//  Sequencer for the 33-bit SIPO shift register.
//  - Accepts a strobed serial bit stream and drives the SIPO's shift enable
//    for exactly FRAME_BITS bits per frame.
//  - Captures the SIPO's parallel word and presents it on a valid/ready

---
 rtl/sipo_frame_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
//   Sequencer for an external FRAME_BITS-wide SIPO shift register.
//   Counts a strobed serial stream into the SIPO and asserts the SIPO shift
//   enable for exactly FRAME_BITS bits. It then captures the parallel word and
//   offers it downstream on a valid/ready handshake. A frame is aborted if the
//   gap between bits grows too long.
//
// Optional feature macro: SIPO_PARITY_CHK_EN
//   When defined, an even-parity check runs over the captured word and drives
//   parity_err. When undefined, parity_err is tied low.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         begin-frame request, honoured in IDLE and in HOLD
//   bit_valid     s_in carries a frame bit this cycle
//   s_in          serial data, forwarded unchanged on sipo_s_in
//   sipo_s_in     serial data to the SIPO
//   sipo_shift    SIPO shift enable
//   sipo_p_out    SIPO parallel output
//   frame         captured frame word
//   frame_valid   frame holds a word the consumer has not yet taken
//   frame_ready   consumer accepts frame
//   busy          controller is not idle
//   bit_cnt       bits shifted into the current frame
//   err_timeout   one-cycle pulse when a partial frame is dropped on gap timeout
//   overrun       sticky flag: a bit arrived outside RECV; cleared by start
//   parity_err    odd number of ones in the captured frame (feature-dependent)
// -----------------------------------------------------------------------------
module sipo_frame_ctrl #(
   parameter int FRAME_BITS = 33,
   parameter int CNT_W      = 6,
   parameter int GAP_MAX    = 255,
   parameter int GAP_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  bit_valid,
   input  logic                  s_in,
   output logic                  sipo_s_in,
   output logic                  sipo_shift,
   input  logic [FRAME_BITS-1:0] sipo_p_out,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic                  busy,
   output logic [CNT_W-1:0]      bit_cnt,
   output logic                  err_timeout,
   output logic                  overrun,
   output logic                  parity_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RECV = 2'd1;
   localparam logic [1:0] S_LOAD = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic                  fvld_q, fvld_d;
   logic                  tmo_q, tmo_d;
   logic                  ovr_q, ovr_d;

   assign sipo_s_in  = s_in;
   assign sipo_shift = (state_q == S_RECV) & bit_valid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      frame_d = frame_q;
      fvld_d  = fvld_q;
      tmo_d   = 1'b0;
      ovr_d   = ovr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RECV;
               cnt_d   = '0;
               gap_d   = '0;
               ovr_d   = 1'b0;
            end
         end
         S_RECV: begin
            if (bit_valid) begin
               cnt_d = cnt_q + 1'b1;
               gap_d = '0;
               if (cnt_q == LAST_BIT) state_d = S_LOAD;
            end else if (gap_q == GAP_LIM - 1'b1) begin
               // This idle cycle is the GAP_MAX-th in a row, so drop the
               // partial frame. The SIPO keeps stale bits, but the next
               // frame shifts all of them out.
               state_d = S_IDLE;
               cnt_d   = '0;
               gap_d   = '0;
               tmo_d   = 1'b1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_LOAD: begin
            frame_d = sipo_p_out;
            fvld_d  = 1'b1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (frame_ready) begin
               fvld_d = 1'b0;
               if (start) begin
                  state_d = S_RECV;
                  cnt_d   = '0;
                  gap_d   = '0;
                  ovr_d   = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A bit that arrives outside RECV is dropped. If it arrives in the same
      // cycle as start, it is still lost, so setting the flag wins over the
      // clear that start requests.
      if (bit_valid && (state_q != S_RECV)) ovr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         frame_q <= '0;
         fvld_q  <= 1'b0;
         tmo_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         frame_q <= frame_d;
         fvld_q  <= fvld_d;
         tmo_q   <= tmo_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef SIPO_PARITY_CHK_EN
   logic par_q, par_d;

   // The parity result is captured together with the frame and cleared when
   // the consumer takes the word.
   always_comb begin
      par_d = par_q;
      if (state_q == S_LOAD) par_d = ^sipo_p_out;
      else if ((state_q == S_HOLD) && frame_ready) par_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end

   assign parity_err = par_q;
`else
   assign parity_err = 1'b0;
`endif

   assign frame       = frame_q;
   assign frame_valid = fvld_q;
   assign busy        = (state_q != S_IDLE);
   assign bit_cnt     = cnt_q;
   assign err_timeout = tmo_q;
   assign overrun     = ovr_q;

endmodule
